serialtl_mem_responder: RTL
===========================

# serialtl_mem_responder

Bit-serial SerialTL manager that sits at the far end of the host-side SerialTL link. It stands in for the SCuM-V chip in FPGA loopback and bring-up builds. It deserializes A-channel request flits from the host serializer and executes Get / PutFullData / PutPartialData against a local 64-bit-wide RAM. It then serializes one D-channel response flit per request back to the host deserializer.

## Interface
Parameters:
- BASE_ADDR, 64'h0000_0000_8000_0000, first byte address served
- DEPTH_WORDS, 256, number of 64-bit RAM words (power of two, ≥2)

Ports:
- clk  in  1  sole clock (link clock)
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  serial request bit valid (from host serializer out_valid)
- in_ready  out  1  responder can accept a request bit
- in_bits  in  1  serial request bit
- out_valid  out  1  serial response bit valid
- out_ready  in  1  host deserializer accepts the response bit
- out_bits  out  1  serial response bit
- busy  out  1  high outside RX_IDLE / RX_SHIFT
- req_count  out  16  completed responses, wraps at 65535→0
- err_count  out  8  error responses plus dropped flits, saturates at 255

## Operation
- Flit is 164 bits, packed MSB→LSB in this order: chanId[2:0], opcode[2:0], param[2:0], size[7:0], source[7:0], address[63:0], data[63:0], corrupt, union[8:0], last. It is sent MSB first, one bit per valid&ready beat, in both directions.
- States:
  - RX_SHIFT: in_ready=1. Shifts in bits and counts to 164.
  - EXEC: 1 cycle. Decodes the flit and accesses the RAM.
  - TX_SHIFT: out_valid=1. Shifts out the 164-bit response, then returns to RX_SHIFT.
- chanId≠0 (not A): flit is dropped, err_count increments, no response, returns to RX_SHIFT.
- Error conditions, each producing an error response:
  - address outside [BASE_ADDR, BASE_ADDR+8·DEPTH_WORDS)
  - size>3
  - address[2:0] not aligned to 2^size
  - opcode not in {0,1,4}
- Word index = (address−BASE_ADDR)>>3.
- Byte mask:
  - PutFullData (op 0): ((1<<2^size)−1)<<address[2:0].
  - PutPartialData (op 1): union[7:0] ANDed with the PutFullData mask.
- Writes update only masked byte lanes. Data is lane-positioned and is not shifted.
- Get (op 4) returns the whole 64-bit word; the host extracts lanes.
- Response fields:
  - chanId=3, param=0, size and source echoed, address=0, union=0, last=1.
  - Opcode is 1 (AccessAckData) for Get, 0 (AccessAck) for Put.
  - data = read word for Get, else 0.
  - corrupt=1 on error, with data=0, opcode per request class (unknown opcode → 0), and no RAM write. err_count increments.
- RAM is not cleared by reset and is zero at configuration.

## Timing
- Reset values: in_ready=0 during reset and 1 the first cycle after deassertion (RX_SHIFT). out_valid=0, out_bits=0, busy=0, counters=0, bit counter=0.
- Last request bit accepted in cycle N → EXEC in N+1 (in_ready=0) → out_valid=1 with the first response bit in N+2.
- out_bits is stable while out_valid&!out_ready. After the 164th accepted response bit, out_valid=0 and in_ready=1 in the next cycle. req_count updates in that same cycle.
- in_valid gaps simply stall the shift, with no timeout. out_ready gaps likewise stall.
- Single outstanding request: in_ready stays 0 throughout EXEC and TX_SHIFT, so no input bits are lost.
- RAM read and write complete in EXEC; a Get immediately after a Put to the same word returns the new data.
- Reset asserted mid-flit: partial RX/TX is discarded and the FSM returns to RX_SHIFT. A RAM write is atomic within EXEC.

## Structure
- Shared header serialtl_defs.vh: FLIT_BITS=164, field widths and bit offsets, chanId codes (A=0, D=3), TL opcodes (PutFull=0, PutPartial=1, Get=4, AccessAck=0, AccessAckData=1).
- Sub-module stl_flit_shifter (parameter DIR): 164-bit shift register plus 8-bit beat counter with a valid/ready serial port and parallel load/done. It is instantiated once for RX and once for TX.
- RAM is an inferred reg array in the top; no vendor primitive.

## Test plan
- Reset → in_ready=0, out_valid=0, counters 0. Release → in_ready=1 next cycle.
- PutFull size 3 addr 0x8000_0010 data 0x1122_3344_5566_7788 src 5, then Get same addr src 6 → AccessAck src 5 corrupt 0; AccessAckData src 6 data 0x1122_3344_5566_7788. req_count=2.
- PutPartial addr 0x8000_0010 union 0x0F data 0xFFFF_FFFF_AABB_CCDD, then Get → data 0x1122_3344_AABB_CCDD.
- Get addr 0x7FFF_FFF8; Get addr 0x8000_0803 size 2 (misaligned) → both corrupt=1, data 0, err_count=2, RAM unchanged.
- Flit with chanId=4 → no response, err_count+1. A following valid Get still answers.
- Random in_valid/out_ready throttling (30% idle), plus reset_n pulsed at TX bit 80 → no bit loss or duplication, FSM back in RX_SHIFT, next request served correctly.

Source files
------------

// File: rtl/serialtl_mem_responder_pkg.sv
// serialtl_mem_responder_pkg: SerialTL flit layout, channel/opcode codes and byte-lane helper.
package serialtl_mem_responder_pkg;
  localparam int FLIT_BITS = 164;
  localparam logic [2:0] CH_A = 3'd0;
  localparam logic [2:0] CH_D = 3'd3;
  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET = 3'd4;
  localparam logic [2:0] OP_ACK = 3'd0;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;
  typedef enum logic [1:0] {RX_SHIFT, EXEC, TX_SHIFT} state_t;
  typedef struct packed {
    logic [2:0]  chan;
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [7:0]  size;
    logic [7:0]  source;
    logic [63:0] address;
    logic [63:0] data;
    logic        corrupt;
    logic [8:0]  user;
    logic        last;
  } flit_t;
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] lo);
    logic [8:0] m;
    m = (9'd1 << (4'd1 << size)) - 9'd1;
    return m[7:0] << lo;
  endfunction
endpackage

// File: rtl/stl_flit_shifter.sv
// stl_flit_shifter: MSB-first flit shift register with beat counter; DIR=0 shifts in, DIR=1 shifts out.
module stl_flit_shifter
  import serialtl_mem_responder_pkg::*;
#(
  parameter bit DIR = 1'b0,
  parameter int W = FLIT_BITS
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_en,
  input  logic         i_beat,
  input  logic         i_bit,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  output logic         o_bit,
  output logic         o_done,
  output logic [W-1:0] o_data
);
  logic [W-1:0] r_sr;
  logic [7:0]   r_cnt;
  logic         w_fire;
  assign w_fire = i_en & i_beat;
  assign o_done = w_fire && r_cnt == 8'(W - 1);
  assign o_bit = r_sr[W-1];
  assign o_data = r_sr;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sr <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sr <= i_data;
      r_cnt <= '0;
    end else if (w_fire) begin
      r_sr <= {r_sr[W-2:0], DIR ? 1'b0 : i_bit};
      r_cnt <= o_done ? 8'd0 : r_cnt + 8'd1;
    end
  end
endmodule

// File: rtl/serialtl_mem_responder.sv
// serialtl_mem_responder: bit-serial TileLink A-channel manager backed by a local 64-bit RAM.
module serialtl_mem_responder
  import serialtl_mem_responder_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_bits,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_bits,
  output logic        busy,
  output logic [15:0] req_count,
  output logic [7:0]  err_count
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [63:0] SPAN = 64'(DEPTH_WORDS) << 3;
  state_t r_state, w_next;
  flit_t w_req, w_rsp;
  logic [63:0] r_ram [DEPTH_WORDS];
  logic [15:0] r_req_count;
  logic [7:0] r_err_count, w_mask;
  logic [63:0] w_off, w_rd;
  logic [AW-1:0] w_idx;
  logic [FLIT_BITS-1:0] w_rx_data, w_unused_tx_data;
  logic w_rx_done, w_tx_done, w_tx_bit, w_unused_rx_bit, w_unused;
  logic w_exec, w_drop, w_err, w_is_get, w_is_put;
  assign in_ready = reset_n && r_state == RX_SHIFT;
  assign out_valid = r_state == TX_SHIFT;
  assign out_bits = out_valid & w_tx_bit;
  assign busy = r_state != RX_SHIFT;
  assign req_count = r_req_count;
  assign err_count = r_err_count;
  assign w_req = flit_t'(w_rx_data);
  assign w_exec = r_state == EXEC;
  assign w_drop = w_req.chan != CH_A;
  assign w_is_get = w_req.opcode == OP_GET;
  assign w_is_put = w_req.opcode == OP_PUT_FULL || w_req.opcode == OP_PUT_PARTIAL;
  assign w_off = w_req.address - BASE_ADDR;
  assign w_idx = w_off[AW+2:3];
  assign w_rd = r_ram[w_idx];
  // size 3 wraps the shifted 3-bit one to zero, giving the full 3'b111 alignment mask
  assign w_err = w_req.address < BASE_ADDR || w_off >= SPAN || w_req.size > 8'd3 ||
                 (w_req.address[2:0] & ((3'd1 << w_req.size[1:0]) - 3'd1)) != 3'd0 ||
                 !(w_is_get || w_is_put);
  assign w_mask = lane_mask(w_req.size[1:0], w_req.address[2:0]) &
                  (w_req.opcode == OP_PUT_PARTIAL ? w_req.user[7:0] : 8'hFF);
  assign w_rsp = '{chan: CH_D, opcode: w_is_get ? OP_ACK_DATA : OP_ACK, param: 3'd0,
                   size: w_req.size, source: w_req.source, address: 64'd0,
                   data: (w_is_get && !w_err) ? w_rd : 64'd0, corrupt: w_err,
                   user: 9'd0, last: 1'b1};
  assign w_unused = ^{w_req.param, w_req.corrupt, w_req.user[8], w_req.last};
  stl_flit_shifter #(.DIR(1'b0)) u_rx (
    .clk(clk), .reset_n(reset_n), .i_en(in_ready), .i_beat(in_valid), .i_bit(in_bits),
    .i_load(1'b0), .i_data('0), .o_bit(w_unused_rx_bit), .o_done(w_rx_done), .o_data(w_rx_data)
  );
  stl_flit_shifter #(.DIR(1'b1)) u_tx (
    .clk(clk), .reset_n(reset_n), .i_en(out_valid), .i_beat(out_ready), .i_bit(1'b0),
    .i_load(w_exec && !w_drop), .i_data(w_rsp), .o_bit(w_tx_bit), .o_done(w_tx_done),
    .o_data(w_unused_tx_data)
  );
  always_comb begin
    w_next = (r_state == RX_SHIFT && w_rx_done) ? EXEC :
             (r_state == EXEC) ? (w_drop ? RX_SHIFT : TX_SHIFT) :
             (r_state == TX_SHIFT && w_tx_done) ? RX_SHIFT : r_state;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RX_SHIFT;
      r_req_count <= '0;
      r_err_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_tx_done) r_req_count <= r_req_count + 16'd1;
      if (w_exec && (w_drop || w_err) && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
    end
  end
  // RAM contents survive reset; only the request path is reset
  always_ff @(posedge clk) begin
    if (w_exec && !w_drop && !w_err && w_is_put)
      for (int i = 0; i < 8; i++)
        if (w_mask[i]) r_ram[w_idx][8*i +: 8] <= w_req.data[8*i +: 8];
  end
endmodule
